// File: rtl/simulador_planta_pkg.sv
// Shared definitions for the bottling-line plant model.
//   - plant FSM state encoding
//   - counter widths (pos, nivel, estoque, indice)
//   - quality-index stepping helper
package simulador_planta_pkg;

  localparam int POS_W     = 8;
  localparam int NIVEL_W   = 8;
  localparam int ESTOQUE_W = 4;
  localparam int INDICE_W  = 8;

  typedef enum logic [1:0] {
    TRANSPORTE_1 = 2'd0,
    ENCHIMENTO   = 2'd1,
    TRANSPORTE_2 = 2'd2,
    VEDACAO      = 2'd3
  } estado_t;

  // Bottle index used for quality rejection: wraps at n, stuck at 0 when n==0.
  function automatic logic [INDICE_W-1:0] proximo_indice(input logic [INDICE_W-1:0] i,
                                                         input int unsigned n);
    if (n == 0) return '0;
    if (i == INDICE_W'(n - 1)) return '0;
    return i + 1'b1;
  endfunction

endpackage

// File: rtl/simulador_planta_if.sv
// Sensor/actuator bus between the line controller and the plant model.
//   master : controller side (drives tick and actuator commands, reads sensors)
//   slave  : plant side (reads commands, drives sensors, counter and fault flag)
interface simulador_planta_if;
  logic       tick;
  logic       MOTOR;
  logic       EV;
  logic       VE;
  logic       repor;
  logic       PG;
  logic       CH;
  logic       RO;
  logic       CQ;
  logic       EB;
  logic [7:0] garrafas_prontas;
  logic       erro;

  modport master (
    output tick, MOTOR, EV, VE, repor,
    input  PG, CH, RO, CQ, EB, garrafas_prontas, erro
  );

  modport slave (
    input  tick, MOTOR, EV, VE, repor,
    output PG, CH, RO, CQ, EB, garrafas_prontas, erro
  );
endinterface

// File: rtl/simulador_planta_detector_borda.sv
// Rising-edge detector.
//   clock, reset_n : clock, synchronous active-low reset
//   in             : level input
//   pulso          : high for the one clock where in=1 and its registered copy is 0
module detector_borda (
  input  logic clock,
  input  logic reset_n,
  input  logic in,
  output logic pulso
);
  logic in_q;

  always_ff @(posedge clock) begin
    if (!reset_n) in_q <= 1'b0;
    else          in_q <= in;
  end

  assign pulso = in & ~in_q;
endmodule

// File: rtl/simulador_planta.sv
// Plant model of the bottling line: one bottle on the conveyor at a time,
// cork stock, finished-bottle counter and sticky fault flag.
//   clock, reset_n : clock, synchronous active-low reset
//   bus (slave)    : tick/MOTOR/EV/VE/repor in; PG/CH/RO/CQ/EB,
//                    garrafas_prontas, erro out (all registered)
module simulador_planta
  import simulador_planta_pkg::*;
#(
  parameter int DIST_ENCHIMENTO = 3,
  parameter int TEMPO_ENCHER    = 4,
  parameter int DIST_VEDACAO    = 2,
  parameter int ESTOQUE_INICIAL = 2,
  parameter int REPROVA_A_CADA  = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  simulador_planta_if.slave   bus
);

  localparam logic [POS_W-1:0]     LIM_1  = POS_W'(DIST_ENCHIMENTO - 1);
  localparam logic [POS_W-1:0]     LIM_2  = POS_W'(DIST_VEDACAO - 1);
  localparam logic [NIVEL_W-1:0]   CHEIO  = NIVEL_W'(TEMPO_ENCHER);
  localparam logic [ESTOQUE_W-1:0] EST_0  = ESTOQUE_W'(ESTOQUE_INICIAL);
  localparam logic [INDICE_W-1:0]  IDX_RP = INDICE_W'(REPROVA_A_CADA - 1);

  estado_t              state, state_n;
  logic [POS_W-1:0]     pos, pos_n;
  logic [NIVEL_W-1:0]   nivel, nivel_n;
  logic                 tampada, tampada_n;
  logic [INDICE_W-1:0]  indice, indice_n;
  logic [ESTOQUE_W-1:0] estoque, estoque_n;
  logic [7:0]           cont, cont_n;
  logic                 erro_q, erro_n;
  logic                 ve_pulso;
  logic                 ch_n;

  detector_borda u_borda_ve (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (bus.VE),
    .pulso   (ve_pulso)
  );

  always_comb begin
    state_n   = state;
    pos_n     = pos;
    nivel_n   = nivel;
    tampada_n = tampada;
    indice_n  = indice;
    estoque_n = estoque;
    cont_n    = cont;
    erro_n    = erro_q;

    // Spill, lost cork and empty-dispenser faults; overflow is handled in ENCHIMENTO.
    if (bus.tick && bus.EV && state != ENCHIMENTO)          erro_n = 1'b1;
    if (ve_pulso && (state != VEDACAO || estoque == '0))    erro_n = 1'b1;

    // Stock runs independently of tick and state; refill wins over a cork edge.
    if (bus.repor)                        estoque_n = EST_0;
    else if (ve_pulso && estoque != '0)   estoque_n = estoque - 1'b1;

    case (state)
      TRANSPORTE_1: if (bus.tick && bus.MOTOR) begin
        if (pos == LIM_1) begin state_n = ENCHIMENTO; pos_n = '0; end
        else               pos_n = pos + 1'b1;
      end
      ENCHIMENTO: if (bus.tick) begin
        // Motor wins: the bottle leaves even if not full, EV ignored that tick.
        if (bus.MOTOR) begin
          state_n = TRANSPORTE_2;
          pos_n   = '0;
        end else if (bus.EV) begin
          if (nivel == CHEIO) erro_n  = 1'b1;
          else                nivel_n = nivel + 1'b1;
        end
      end
      TRANSPORTE_2: if (bus.tick && bus.MOTOR) begin
        if (pos == LIM_2) begin state_n = VEDACAO; pos_n = '0; end
        else               pos_n = pos + 1'b1;
      end
      VEDACAO: begin
        if (ve_pulso && estoque != '0) tampada_n = 1'b1;
        if (bus.tick && bus.MOTOR) begin
          if (nivel == CHEIO && tampada) cont_n = cont + 1'b1;
          indice_n  = proximo_indice(indice, REPROVA_A_CADA);
          nivel_n   = '0;
          tampada_n = 1'b0;
          pos_n     = '0;
          state_n   = TRANSPORTE_1;
        end
      end
      default: state_n = TRANSPORTE_1;
    endcase

    ch_n = (state_n == ENCHIMENTO) && (nivel_n == CHEIO);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= TRANSPORTE_1;
      pos     <= '0;
      nivel   <= '0;
      tampada <= 1'b0;
      indice  <= '0;
      estoque <= EST_0;
      cont    <= '0;
      erro_q  <= 1'b0;
      bus.PG  <= 1'b0;
      bus.CH  <= 1'b0;
      bus.EB  <= 1'b0;
      bus.CQ  <= 1'b0;
      bus.RO  <= (EST_0 != '0);
    end else begin
      state   <= state_n;
      pos     <= pos_n;
      nivel   <= nivel_n;
      tampada <= tampada_n;
      indice  <= indice_n;
      estoque <= estoque_n;
      cont    <= cont_n;
      erro_q  <= erro_n;
      // Sensors decoded from next-state values so they line up with the state register.
      bus.PG  <= (state_n == ENCHIMENTO);
      bus.CH  <= ch_n;
      bus.EB  <= (state_n == VEDACAO);
      bus.CQ  <= ch_n & ~((REPROVA_A_CADA != 0) && (indice_n == IDX_RP));
      bus.RO  <= (estoque_n != '0);
    end
  end

  assign bus.garrafas_prontas = cont;
  assign bus.erro             = erro_q;

endmodule
